// File: rtl/data_unpacker_pkg.sv
// data_unpacker_pkg: shared state type and width helpers for the data unpacker
package data_unpacker_pkg;
  typedef enum logic {EMPTY, SPLIT} state_e;
  function automatic int c_log_2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int num_slices(input int iw, input int ow);
    return (iw + ow - 1) / ow;
  endfunction
endpackage

// File: rtl/data_unpacker_if.sv
// data_unpacker_if: wide write channel in (s_*) and narrow write channel out (m_*)
// slave modport = unpacker side, master modport = surrounding producer/consumer
interface data_unpacker_if #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 64
);
  logic                 s_write_req;
  logic                 s_write_ready;
  logic [IN_WIDTH-1:0]  s_write_data;
  logic                 m_write_req;
  logic                 m_write_ready;
  logic [OUT_WIDTH-1:0] m_write_data;
  logic                 m_write_last;
  modport slave (
    input  s_write_req, s_write_data, m_write_ready,
    output s_write_ready, m_write_req, m_write_data, m_write_last
  );
  modport master (
    output s_write_req, s_write_data, m_write_ready,
    input  s_write_ready, m_write_req, m_write_data, m_write_last
  );
endinterface

// File: rtl/data_unpacker_stats.sv
// unpacker_stats: saturating counters of narrow transfers and stalled cycles
// ports: clk, reset (sync, active-low), word_i/stall_i event strobes, words_o/stalls_o counts
module unpacker_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        word_i,
  input  logic        stall_i,
  output logic [31:0] words_o,
  output logic [31:0] stalls_o
);
  logic [31:0] words_q, stalls_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      words_q  <= '0;
      stalls_q <= '0;
    end else begin
      words_q  <= (word_i && !(&words_q)) ? words_q + 32'd1 : words_q;
      stalls_q <= (stall_i && !(&stalls_q)) ? stalls_q + 32'd1 : stalls_q;
    end
  end
  assign words_o  = words_q;
  assign stalls_o = stalls_q;
endmodule

// File: rtl/data_unpacker.sv
// data_unpacker: splits one IN_WIDTH word into ceil(IN_WIDTH/OUT_WIDTH) OUT_WIDTH words, LSB slice first
// ports: clk, reset (sync, active-low), bus (data_unpacker_if.slave: s_* wide in, m_* narrow out)
// UNPACKER_STATS_EN adds stat_words_out / stat_stall_cycles saturating counters
module data_unpacker
  import data_unpacker_pkg::*;
#(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 64,
  parameter int OP_WIDTH  = 16
) (
  input logic clk,
  input logic reset,
  data_unpacker_if.slave bus
`ifdef UNPACKER_STATS_EN
  ,
  output logic [31:0] stat_words_out,
  output logic [31:0] stat_stall_cycles
`endif
);
  localparam int NUM   = num_slices(IN_WIDTH, OUT_WIDTH);
  localparam int CNT_W = c_log_2(NUM) > 0 ? c_log_2(NUM) : 1;
  // hold is padded to a whole number of slices so the final slice zero-fills
  localparam int HW    = NUM * OUT_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM - 1);
  if (OUT_WIDTH % OP_WIDTH != 0) begin : g_width_chk
    $error("OUT_WIDTH must be a multiple of OP_WIDTH");
  end
  state_e           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_last, m_acc, s_rdy, s_acc;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    at_last = state_q == SPLIT && cnt_q == CNT_LAST;
    m_acc   = state_q == SPLIT && bus.m_write_ready;
    // the final slice leaving frees the holding register in the same cycle
    s_rdy   = state_q == EMPTY || (bus.m_write_ready && cnt_q == CNT_LAST);
    s_acc   = bus.s_write_req && s_rdy;
    state_d = s_acc ? SPLIT : (m_acc && at_last) ? EMPTY : state_q;
    hold_d  = s_acc ? HW'(bus.s_write_data) : m_acc ? hold_q >> OUT_WIDTH : hold_q;
    cnt_d   = s_acc ? '0 : m_acc ? (at_last ? '0 : cnt_q + 1'b1) : cnt_q;
  end
  assign bus.s_write_ready = s_rdy;
  assign bus.m_write_req   = state_q == SPLIT;
  assign bus.m_write_data  = hold_q[OUT_WIDTH-1:0];
  assign bus.m_write_last  = at_last;
`ifdef UNPACKER_STATS_EN
  unpacker_stats u_stats (
    .clk     (clk),
    .reset   (reset),
    .word_i  (m_acc),
    .stall_i (state_q == SPLIT && !bus.m_write_ready),
    .words_o (stat_words_out),
    .stalls_o(stat_stall_cycles)
  );
`endif
endmodule

// File: tb/tb_data_unpacker.sv
// tb_data_unpacker: directed checks of data_unpacker at 128/64 and 96/64
module tb_data_unpacker;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  data_unpacker_if #(.IN_WIDTH(128), .OUT_WIDTH(64)) ifa ();
  data_unpacker_if #(.IN_WIDTH(96), .OUT_WIDTH(64)) ifb ();
`ifdef UNPACKER_STATS_EN
  logic [31:0] a_words, a_stalls, b_words, b_stalls;
`endif
  data_unpacker #(.IN_WIDTH(128), .OUT_WIDTH(64), .OP_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
`ifdef UNPACKER_STATS_EN
    , .stat_words_out(a_words), .stat_stall_cycles(a_stalls)
`endif
  );
  data_unpacker #(.IN_WIDTH(96), .OUT_WIDTH(64), .OP_WIDTH(16)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
`ifdef UNPACKER_STATS_EN
    , .stat_words_out(b_words), .stat_stall_cycles(b_stalls)
`endif
  );
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_a(input string tag, input logic req, input logic [63:0] data,
                       input logic last, input logic srdy);
    check({tag, ".req"}, 128'(ifa.m_write_req), 128'(req));
    check({tag, ".data"}, 128'(ifa.m_write_data), 128'(data));
    check({tag, ".last"}, 128'(ifa.m_write_last), 128'(last));
    check({tag, ".sready"}, 128'(ifa.s_write_ready), 128'(srdy));
  endtask
  task automatic chk_b(input string tag, input logic req, input logic [63:0] data,
                       input logic last, input logic srdy);
    check({tag, ".req"}, 128'(ifb.m_write_req), 128'(req));
    check({tag, ".data"}, 128'(ifb.m_write_data), 128'(data));
    check({tag, ".last"}, 128'(ifb.m_write_last), 128'(last));
    check({tag, ".sready"}, 128'(ifb.s_write_ready), 128'(srdy));
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  logic [127:0] w [0:7];
  initial begin
    w[0] = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_1234_5678;
    w[1] = {64'hAAAA_AAAA_BBBB_BBBB, 64'h1111_1111_2222_2222};
    w[2] = 128'h0F0F_0F0F_0F0F_0F0F_F0F0_F0F0_F0F0_F0F0;
    w[3] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    w[4] = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
    w[5] = 128'h1357_9BDF_2468_ACE0_0246_8ACE_1357_9BDF;
    w[6] = 128'hFFFF_0000_FFFF_0000_0000_FFFF_0000_FFFF;
    w[7] = 128'h8000_0000_0000_0001_0000_0000_0000_0080;
    ifa.s_write_req = 1'b1; ifa.s_write_data = w[0]; ifa.m_write_ready = 1'b1;
    ifb.s_write_req = 1'b0; ifb.s_write_data = '0; ifb.m_write_ready = 1'b1;
    // reset held low with a pending wide word
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("reset", 1'b0, 64'h0, 1'b0, 1'b1);
    end
    chk_b("reset_b", 1'b0, 64'h0, 1'b0, 1'b1);
    reset = 1'b1; ifa.s_write_req = 1'b0;
    tick();
    chk_a("idle", 1'b0, 64'h0, 1'b0, 1'b1);
    // single word split
    ifa.s_write_req = 1'b1; ifa.s_write_data = w[1];
    tick();
    ifa.s_write_req = 1'b0;
    chk_a("w1_lo", 1'b1, 64'h1111_1111_2222_2222, 1'b0, 1'b0);
    tick();
    chk_a("w1_hi", 1'b1, 64'hAAAA_AAAA_BBBB_BBBB, 1'b1, 1'b1);
    tick();
    chk_a("w1_done", 1'b0, 64'h0, 1'b0, 1'b1);
    // back-to-back stream, no bubbles
    ifa.s_write_req = 1'b1; ifa.s_write_data = w[2];
    tick();
    for (int i = 2; i < 5; i++) begin
      ifa.s_write_req = i < 4;
      if (i < 4) ifa.s_write_data = w[i+1];
      #1;
      chk_a($sformatf("stream%0d_lo", i), 1'b1, w[i][63:0], 1'b0, 1'b0);
      tick();
      chk_a($sformatf("stream%0d_hi", i), 1'b1, w[i][127:64], 1'b1, 1'b1);
      tick();
    end
    chk_a("stream_done", 1'b0, 64'h0, 1'b0, 1'b1);
    // consumer stall mid-word
    ifa.s_write_req = 1'b1; ifa.s_write_data = w[5];
    tick();
    ifa.s_write_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ifa.m_write_ready = 1'b0;
      #1;
      chk_a($sformatf("stall%0d", i), 1'b1, w[5][63:0], 1'b0, 1'b0);
      tick();
    end
    ifa.m_write_ready = 1'b1;
    #1;
    chk_a("stall_release", 1'b1, w[5][63:0], 1'b0, 1'b0);
    tick();
    chk_a("stall_hi", 1'b1, w[5][127:64], 1'b1, 1'b1);
    tick();
    chk_a("stall_done", 1'b0, 64'h0, 1'b0, 1'b1);
`ifdef UNPACKER_STATS_EN
    check("stat_words", 128'(a_words), 128'd10);
    check("stat_stalls", 128'(a_stalls), 128'd5);
`endif
    // non-divisible 96/64
    ifb.s_write_req = 1'b1; ifb.s_write_data = 96'h0123_4567_89AB_CDEF_0011_2233;
    tick();
    ifb.s_write_req = 1'b0;
    chk_b("b_lo", 1'b1, 64'h89AB_CDEF_0011_2233, 1'b0, 1'b0);
    tick();
    chk_b("b_hi", 1'b1, 64'h0000_0000_0123_4567, 1'b1, 1'b1);
    tick();
    chk_b("b_done", 1'b0, 64'h0, 1'b0, 1'b1);
    // reset after first slice discards the rest
    ifa.s_write_req = 1'b1; ifa.s_write_data = w[6];
    tick();
    ifa.s_write_req = 1'b0;
    chk_a("rst6_lo", 1'b1, w[6][63:0], 1'b0, 1'b0);
    tick();
    chk_a("rst6_hi", 1'b1, w[6][127:64], 1'b1, 1'b1);
    reset = 1'b0;
    tick();
    chk_a("rst6_reset", 1'b0, 64'h0, 1'b0, 1'b1);
`ifdef UNPACKER_STATS_EN
    check("stat_words_clr", 128'(a_words), 128'd0);
    check("stat_stalls_clr", 128'(a_stalls), 128'd0);
`endif
    reset = 1'b1;
    tick();
    chk_a("rst6_gone", 1'b0, 64'h0, 1'b0, 1'b1);
    ifa.s_write_req = 1'b1; ifa.s_write_data = w[7];
    tick();
    ifa.s_write_req = 1'b0;
    chk_a("w7_lo", 1'b1, w[7][63:0], 1'b0, 1'b0);
    tick();
    chk_a("w7_hi", 1'b1, w[7][127:64], 1'b1, 1'b1);
    tick();
    chk_a("w7_done", 1'b0, 64'h0, 1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
